// File: rtl/ibex_pkg.sv
// Shared types for the writeback lockstep comparator: FSM states and the
// regfile write packet that travels through the lockstep delay line.
package ibex_pkg;

  localparam int unsigned WbAddrWidth    = 5;
  localparam int unsigned WbMaxDataWidth = 64;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_MISMATCH,
    LS_RECOVER,
    LS_FATAL
  } ls_state_e;

  // wdata is sized for the widest supported core; narrower data is zero-extended.
  typedef struct packed {
    logic                      we;
    logic [WbAddrWidth-1:0]    waddr;
    logic [WbMaxDataWidth-1:0] wdata;
  } wb_pkt_t;

  // Two idle write ports always agree, whatever junk sits on addr/data.
  function automatic logic wb_pkt_differs(input wb_pkt_t a, input wb_pkt_t b);
    return (a.we != b.we) || (a.we && ((a.waddr != b.waddr) || (a.wdata != b.wdata)));
  endfunction

endpackage

// File: rtl/ibex_wb_delay_line.sv
// Fixed-depth shift register delaying the main-core write packet so it lines
// up with the shadow core; flush_i invalidates every stage for the next cycle.
module ibex_wb_delay_line
  import ibex_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    flush_i,
  input  logic    in_valid_i,
  input  wb_pkt_t in_pkt_i,
  output logic    out_valid_o,
  output wb_pkt_t out_pkt_o
);

  localparam logic [WbMaxDataWidth-1:0] DataMask = WbMaxDataWidth'({DataWidth{1'b1}});

  wb_pkt_t w_in_pkt;

  always_comb begin
    w_in_pkt       = in_pkt_i;
    w_in_pkt.wdata = in_pkt_i.wdata & DataMask;
  end

  for (genvar g = 0; g < Depth; g++) begin : g_stage
    logic    r_valid;
    wb_pkt_t r_pkt;
    logic    w_src_valid;
    wb_pkt_t w_src_pkt;

    if (g == 0) begin : g_head
      assign w_src_valid = in_valid_i;
      assign w_src_pkt   = w_in_pkt;
    end else begin : g_body
      assign w_src_valid = g_stage[g-1].r_valid;
      assign w_src_pkt   = g_stage[g-1].r_pkt;
    end

    // NOTE: these stages are plain flops, not a RAM macro, so clearing the
    // payload on reset costs nothing and keeps the compare path deterministic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= 1'b0;
        r_pkt   <= '0;
      end else begin
        r_valid <= w_src_valid & ~flush_i;
        r_pkt   <= w_src_pkt;
      end
    end
  end

  assign out_valid_o = g_stage[Depth-1].r_valid;
  assign out_pkt_o   = g_stage[Depth-1].r_pkt;

endmodule

// File: rtl/ibex_wb_lockstep_cmp.sv
// Compares main-core regfile writes against the delayed shadow core and drives
// rollback / flush / fatal signalling through a small retry FSM.
module ibex_wb_lockstep_cmp
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LockstepOffset = 2,
  parameter int unsigned RecoverCycles  = 4,
  parameter int unsigned MaxRetries     = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 main_we_i,
  input  logic [4:0]           main_waddr_i,
  input  logic [DataWidth-1:0] main_wdata_i,
  input  logic                 shadow_we_i,
  input  logic [4:0]           shadow_waddr_i,
  input  logic [DataWidth-1:0] shadow_wdata_i,
  output logic                 mismatch_o,
  output logic                 flush_o,
  output logic                 fatal_o,
  output logic [2:0]           retry_cnt_o
);

  localparam logic [2:0] RetryLimit = 3'(MaxRetries);
  localparam logic [3:0] RecLoad    = 4'(RecoverCycles - 1);
  localparam logic [4:0] CleanLast  = 5'd30;

  ls_state_e  r_state;
  ls_state_e  w_state_nxt;
  logic [3:0] r_rec_cnt;
  logic [2:0] r_retry_cnt;
  logic [2:0] w_retry_inc;
  logic [4:0] r_clean_cnt;
  logic       r_mismatch;
  logic       r_flush;
  logic       r_fatal;

  wb_pkt_t    w_main_pkt;
  wb_pkt_t    w_shadow_pkt;
  wb_pkt_t    w_dly_pkt;
  logic       w_dly_valid;
  logic       w_cmp_en;
  logic       w_miss;
  logic       w_clean;

  assign w_main_pkt   = '{we: main_we_i, waddr: main_waddr_i,
                          wdata: WbMaxDataWidth'(main_wdata_i)};
  assign w_shadow_pkt = '{we: shadow_we_i, waddr: shadow_waddr_i,
                          wdata: WbMaxDataWidth'(shadow_wdata_i)};

  ibex_wb_delay_line #(
    .Depth     (LockstepOffset),
    .DataWidth (DataWidth)
  ) u_delay_line (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (r_state == LS_RECOVER),
    .in_valid_i  (1'b1),
    .in_pkt_i    (w_main_pkt),
    .out_valid_o (w_dly_valid),
    .out_pkt_o   (w_dly_pkt)
  );

  // Outside IDLE the core is being flushed or is dead, so nothing is compared.
  assign w_cmp_en = (r_state == LS_IDLE) && w_dly_valid;
  assign w_miss   = w_cmp_en && wb_pkt_differs(w_dly_pkt, w_shadow_pkt);
  assign w_clean  = (r_state == LS_IDLE) && !w_miss;

  assign w_retry_inc = (r_retry_cnt == RetryLimit) ? r_retry_cnt : r_retry_cnt + 3'd1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LS_IDLE:     if (w_miss) w_state_nxt = LS_MISMATCH;
      LS_MISMATCH: w_state_nxt = (w_retry_inc == RetryLimit) ? LS_FATAL : LS_RECOVER;
      LS_RECOVER:  if (r_rec_cnt == 4'd0) w_state_nxt = LS_IDLE;
      LS_FATAL:    w_state_nxt = LS_FATAL;
      default:     w_state_nxt = LS_IDLE;
    endcase
  end

  // NOTE: state and counters use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= LS_IDLE;
      r_rec_cnt   <= '0;
      r_retry_cnt <= '0;
      r_clean_cnt <= '0;
      r_mismatch  <= 1'b0;
      r_flush     <= 1'b0;
      r_fatal     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mismatch <= (w_state_nxt == LS_MISMATCH);
      r_flush    <= (w_state_nxt == LS_MISMATCH) || (w_state_nxt == LS_RECOVER);
      r_fatal    <= (w_state_nxt == LS_FATAL);

      if (r_state == LS_MISMATCH) begin
        r_rec_cnt <= RecLoad;
      end else if ((r_state == LS_RECOVER) && (r_rec_cnt != 4'd0)) begin
        r_rec_cnt <= r_rec_cnt - 4'd1;
      end

      // The 5-bit window wraps naturally after 31.
      if (w_clean) begin
        r_clean_cnt <= r_clean_cnt + 5'd1;
      end else begin
        r_clean_cnt <= '0;
      end

      // A full 31-cycle clean window matches one regfile backup period.
      if (r_state == LS_MISMATCH) begin
        r_retry_cnt <= w_retry_inc;
      end else if (w_clean && (r_clean_cnt == CleanLast)) begin
        r_retry_cnt <= '0;
      end
    end
  end

  assign mismatch_o  = r_mismatch;
  assign flush_o     = r_flush;
  assign fatal_o     = r_fatal;
  assign retry_cnt_o = r_retry_cnt;

endmodule

// File: tb/tb_ibex_wb_lockstep_cmp.sv
// Directed bench for ibex_wb_lockstep_cmp at default parameters
// (offset 2, 4 recover cycles, 3 retries, 32-bit data).
module tb_ibex_wb_lockstep_cmp;

  localparam logic [31:0] DGood = 32'hDEADBEEF;
  localparam logic [31:0] DBad  = 32'hDEADBEEE;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        main_we_i = 1'b0;
  logic [4:0]  main_waddr_i = '0;
  logic [31:0] main_wdata_i = '0;
  logic        shadow_we_i = 1'b0;
  logic [4:0]  shadow_waddr_i = '0;
  logic [31:0] shadow_wdata_i = '0;
  logic        mismatch_o;
  logic        flush_o;
  logic        fatal_o;
  logic [2:0]  retry_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  ibex_wb_lockstep_cmp dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .main_we_i      (main_we_i),
    .main_waddr_i   (main_waddr_i),
    .main_wdata_i   (main_wdata_i),
    .shadow_we_i    (shadow_we_i),
    .shadow_waddr_i (shadow_waddr_i),
    .shadow_wdata_i (shadow_wdata_i),
    .mismatch_o     (mismatch_o),
    .flush_o        (flush_o),
    .fatal_o        (fatal_o),
    .retry_cnt_o    (retry_cnt_o)
  );

  // One clock cycle: apply inputs, step past the edge, leave outputs settled.
  task automatic cyc(input logic mwe, input logic [4:0] ma, input logic [31:0] md,
                     input logic swe, input logic [4:0] sa, input logic [31:0] sd);
    main_we_i      = mwe;
    main_waddr_i   = ma;
    main_wdata_i   = md;
    shadow_we_i    = swe;
    shadow_waddr_i = sa;
    shadow_wdata_i = sd;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc_same(input logic we, input logic [4:0] a, input logic [31:0] d);
    cyc(we, a, d, we, a, d);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    main_we_i = 1'b0;
    shadow_we_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    n_cmp++;
    if ({mismatch_o, flush_o, fatal_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: {mis,flush,fatal}=%b expected 000", {mismatch_o, flush_o, fatal_o});
    end
    n_cmp++;
    if (retry_cnt_o !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_retry: retry_cnt_o=%0d expected 0", retry_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_identical();
    for (int i = 0; i < 40; i++) begin
      cyc_same(1'b1, 5'd5, DGood);
      n_cmp++;
      if ({mismatch_o, flush_o, fatal_o} !== 3'b000) begin
        n_bad++;
        $display("FAIL identical_c%0d: {mis,flush,fatal}=%b expected 000", i, {mismatch_o, flush_o, fatal_o});
      end
    end
    n_cmp++;
    if (retry_cnt_o !== 3'd0) begin
      n_bad++;
      $display("FAIL identical_retry: retry_cnt_o=%0d expected 0", retry_cnt_o);
    end
  endtask

  task automatic test_data_miss();
    cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
    n_cmp++;
    if ({mismatch_o, flush_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL data_miss_t1: {mis,flush}=%b expected 11", {mismatch_o, flush_o});
    end
    for (int k = 1; k <= 5; k++) begin
      cyc_same(1'b1, 5'd5, DGood);
      n_cmp++;
      if ({mismatch_o, flush_o} !== {1'b0, (k <= 4)}) begin
        n_bad++;
        $display("FAIL data_miss_t%0d: {mis,flush}=%b expected %b", k + 1, {mismatch_o, flush_o}, {1'b0, (k <= 4)});
      end
      n_cmp++;
      if (retry_cnt_o !== 3'd1) begin
        n_bad++;
        $display("FAIL data_miss_retry_t%0d: retry_cnt_o=%0d expected 1", k + 1, retry_cnt_o);
      end
    end
    // Two refill cycles: delay line still invalid, shadow junk must be ignored.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 5'd5, DGood, 1'b1, 5'd9, 32'h0BAD0BAD);
      n_cmp++;
      if (mismatch_o !== 1'b0) begin
        n_bad++;
        $display("FAIL refill_c%0d: mismatch_o=%b expected 0", k, mismatch_o);
      end
    end
    cyc(1'b1, 5'd5, DGood, 1'b1, 5'd9, 32'h0BAD0BAD);
    n_cmp++;
    if (mismatch_o !== 1'b1) begin
      n_bad++;
      $display("FAIL refill_c2: mismatch_o=%b expected 1", mismatch_o);
    end
    repeat (5) cyc_same(1'b1, 5'd5, DGood);
    n_cmp++;
    if (retry_cnt_o !== 3'd2) begin
      n_bad++;
      $display("FAIL refill_retry: retry_cnt_o=%0d expected 2", retry_cnt_o);
    end
  endtask

  task automatic test_we_miss();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc_same(1'b1, 5'd7, 32'h12345678);
      n_cmp++;
      if (mismatch_o !== 1'b0) begin
        n_bad++;
        $display("FAIL we_fill_c%0d: mismatch_o=%b expected 0", i, mismatch_o);
      end
    end
    cyc(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd7, 32'h12345678);
    n_cmp++;
    if (mismatch_o !== 1'b1) begin
      n_bad++;
      $display("FAIL we_main_only: mismatch_o=%b expected 1", mismatch_o);
    end
    do_reset();
    repeat (2) cyc_same(1'b0, 5'd3, 32'hAAAA5555);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 5'd3, 32'hAAAA5555, 1'b0, 5'd9, 32'h5555AAAA);
      n_cmp++;
      if (mismatch_o !== 1'b0) begin
        n_bad++;
        $display("FAIL we_both_low_c%0d: mismatch_o=%b expected 0", i, mismatch_o);
      end
    end
    cyc(1'b0, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 32'hAAAA5555);
    n_cmp++;
    if (mismatch_o !== 1'b1) begin
      n_bad++;
      $display("FAIL we_shadow_only: mismatch_o=%b expected 1", mismatch_o);
    end
  endtask

  task automatic test_fatal();
    do_reset();
    repeat (3) cyc_same(1'b1, 5'd5, DGood);
    for (int m = 1; m <= 3; m++) begin
      cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
      n_cmp++;
      if (mismatch_o !== 1'b1) begin
        n_bad++;
        $display("FAIL fatal_miss%0d: mismatch_o=%b expected 1", m, mismatch_o);
      end
      if (m < 3) begin
        repeat (9) cyc_same(1'b1, 5'd5, DGood);
        n_cmp++;
        if (retry_cnt_o !== 3'(m)) begin
          n_bad++;
          $display("FAIL fatal_retry%0d: retry_cnt_o=%0d expected %0d", m, retry_cnt_o, m);
        end
      end
    end
    cyc_same(1'b1, 5'd5, DGood);
    n_cmp++;
    if ({mismatch_o, flush_o, fatal_o, retry_cnt_o} !== {3'b001, 3'd3}) begin
      n_bad++;
      $display("FAIL fatal_entry: {mis,flush,fatal}=%b retry=%0d expected 001 retry=3",
               {mismatch_o, flush_o, fatal_o}, retry_cnt_o);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 5'd5, DGood, 1'b0, 5'd1, 32'h0);
      n_cmp++;
      if ({mismatch_o, flush_o, fatal_o} !== 3'b001) begin
        n_bad++;
        $display("FAIL fatal_sticky_c%0d: {mis,flush,fatal}=%b expected 001", i, {mismatch_o, flush_o, fatal_o});
      end
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({fatal_o, retry_cnt_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL fatal_reset: fatal=%b retry=%0d expected 0/0", fatal_o, retry_cnt_o);
    end
  endtask

  task automatic test_clean_window();
    do_reset();
    repeat (3) cyc_same(1'b1, 5'd5, DGood);
    cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
    repeat (5) cyc_same(1'b1, 5'd5, DGood);
    repeat (30) cyc_same(1'b1, 5'd5, DGood);
    n_cmp++;
    if (retry_cnt_o !== 3'd1) begin
      n_bad++;
      $display("FAIL clean_30: retry_cnt_o=%0d expected 1", retry_cnt_o);
    end
    cyc_same(1'b1, 5'd5, DGood);
    n_cmp++;
    if (retry_cnt_o !== 3'd0) begin
      n_bad++;
      $display("FAIL clean_31: retry_cnt_o=%0d expected 0", retry_cnt_o);
    end
    repeat (5) cyc_same(1'b1, 5'd5, DGood);
    cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
    n_cmp++;
    if (mismatch_o !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_late_miss: mismatch_o=%b expected 1", mismatch_o);
    end
    repeat (5) cyc_same(1'b1, 5'd5, DGood);
    n_cmp++;
    if (retry_cnt_o !== 3'd1) begin
      n_bad++;
      $display("FAIL clean_late_retry: retry_cnt_o=%0d expected 1", retry_cnt_o);
    end
  endtask

  task automatic test_reset_in_recover();
    do_reset();
    repeat (3) cyc_same(1'b1, 5'd5, DGood);
    cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
    repeat (2) cyc_same(1'b1, 5'd5, DGood);
    n_cmp++;
    if ({mismatch_o, flush_o, retry_cnt_o} !== {2'b01, 3'd1}) begin
      n_bad++;
      $display("FAIL rec2_state: {mis,flush}=%b retry=%0d expected 01 retry=1", {mismatch_o, flush_o}, retry_cnt_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({mismatch_o, flush_o, fatal_o, retry_cnt_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL rec2_async_reset: {mis,flush,fatal}=%b retry=%0d expected 000 retry=0",
               {mismatch_o, flush_o, fatal_o}, retry_cnt_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
      n_cmp++;
      if (mismatch_o !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_c%0d: mismatch_o=%b expected 0", k, mismatch_o);
      end
    end
    cyc(1'b1, 5'd5, DGood, 1'b1, 5'd5, DBad);
    n_cmp++;
    if (mismatch_o !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_c2: mismatch_o=%b expected 1", mismatch_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identical();
    test_data_miss();
    test_we_miss();
    test_fatal();
    test_clean_window();
    test_reset_in_recover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
